serial_adder: RTL

- Bit-serial N-bit ripple adder built around the lab's one-bit full-adder cell.
- Feeds one LSB pair per clock into a single FA instance and registers that cell's carry-out back into its carry-in.
- Shifts each sum bit into a result register.
- Sits directly upstream and downstream of the FA cell, turning it into a multi-cycle datapath stage with a start/done handshake.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 33 +++
 rtl/serial_adder_fa.sv | 11 +
 rtl/serial_adder.sv | 118 +++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and width helper for the bit-serial adder.
// Optional overflow flag is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         co;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    modport master (
        output start, a, b, ci,
        input  busy, done, sum, co
`ifdef SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, sum, co
`ifdef SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full adder cell; the combinational core of the serial adder.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one LSB pair per clock through a single FA cell.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement ovf output.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int            CW   = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          co_q, co_d;
    logic          done_q, done_d;
    logic          fa_sum, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    serial_adder_fa u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .ci  (carry_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.ci;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {fa_sum, res_q[N-1:1]};
                carry_d = fa_co;
                cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
                // Final bit: carry_q here is the carry into the MSB.
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    sum_d   = res_d;
                    co_d    = fa_co;
                    done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_co;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule
